alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared, externally registered ALU.
// Latency: legal op -> rsp_valid 3 edges after accept; illegal op -> 1 edge.
// Backpressure: one op in flight; requests wait (ready=0) until the response handshakes.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   req{0,1}_valid/_ready         request handshake (ready is combinational, IDLE only)
//   req{0,1}_a/_b/_sel            operands and opcode (000 add, 001 B-A, 010 mul, 011 A, 100 B)
//   alu_a/alu_b/alu_sel           registered operands/opcode to the shared ALU
//   alu_out/alu_z                 ALU result and zero flag, valid one edge after operands
//   rsp_valid/_ready              response handshake
//   rsp_id/_data/_z/_err          owner, result, zero flag, illegal-opcode flag
// Build option: define ALU_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_z,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_z_q, rsp_z_d;
  logic             rsp_err_q, rsp_err_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic             last_grant_q, last_grant_d;
`endif

  logic             grant_id;   // requester chosen this cycle (meaningful only with accept)
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;
  logic             sel_legal;

  // Arbitration: a lone requester always wins; ties depend on the build option.
  always_comb begin
    grant_id = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~req0_valid;
    end
`else
    grant_id = ~req0_valid;
`endif
  end

  // Reset gates accept so no ready pulse can leak out while reset is held.
  assign accept     = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign sel_a     = grant_id ? req1_a   : req0_a;
  assign sel_b     = grant_id ? req1_b   : req0_b;
  assign sel_op    = grant_id ? req1_sel : req0_sel;
  assign sel_legal = (sel_op <= 3'b100);

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_z_d     = rsp_z_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_id_d = grant_id;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_grant_d = grant_id;
`endif
          if (sel_legal) begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_sel_d = sel_op;
            state_d   = ISSUE;
          end else begin
            // Illegal opcode never touches the ALU; answer immediately.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_z_d     = 1'b0;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        // ALU registers the held operands on this edge.
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_z_d     = alu_z;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_z_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_z_q     <= rsp_z_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered reference ALU attached.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_sel = '0, req1_sel = '0;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [15:0] alu_out = '0;
  logic        alu_z = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_z, rsp_err;
  logic [15:0] rsp_data;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference registered ALU: result appears one edge after operands.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    logic [15:0] m;
    m = a * b;
    case (s)
      3'b000:  return a + b;
      3'b001:  return b - a;
      3'b010:  return m;
      3'b011:  return a;
      3'b100:  return b;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_out <= alu_f(alu_a, alu_b, alu_sel);
    alu_z   <= (alu_f(alu_a, alu_b, alu_sel) == 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from a single requester, through to its response handshake.
  task automatic op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel,
                    input int exp_lat, input logic [15:0] exp_d, input logic exp_z, input logic exp_err,
                    input string tag);
    int n;
    if (id) begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    chk({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end while (rsp_valid !== 1'b1 && n < 12);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_z"}, rsp_z, exp_z);
    chk({tag, "_err"}, rsp_err, exp_err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_valid_clear"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    int ng;
    int nr;
    logic [3:0] gseq;
    logic both_hi;
    logic bad;

    // Reset with a request pending: ready must stay low.
    reset = 1'b1;
    req0_valid = 1'b1;
    tick();
    tick();
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_flags", {rsp_z, rsp_err}, 0);
    chk("reset_alu", {alu_a, alu_b, 13'(alu_sel)}, 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Single request: 60 + 62.
    op(1'b0, 16'd60, 16'd62, 3'b000, 3, 16'd122, 1'b0, 1'b0, "single_add");

    // Simultaneous after reset: req0 sub (0, z) first, then req1 mul.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_a = 16'd40; req0_b = 16'd40; req0_sel = 3'b001; req0_valid = 1'b1;
    req1_a = 16'd40; req1_b = 16'd40; req1_sel = 3'b010; req1_valid = 1'b1;
    #1;
    chk("sim_first_grant0", req0_ready, 1);
    chk("sim_first_grant1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin tick(); n++; end
    chk("sim_first_lat", n, 3);
    chk("sim_first_rsp", {15'd0, rsp_id, rsp_data, rsp_z}, {15'd0, 1'b0, 16'd0, 1'b1});
    rsp_ready = 1'b1;
    #1;
    chk("sim_handshake_no_accept", req1_ready, 0);
    tick();
    rsp_ready = 1'b0;
    chk("sim_second_grant", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin tick(); n++; end
    chk("sim_second_rsp", {15'd0, rsp_id, rsp_data, rsp_z}, {15'd0, 1'b1, 16'd1600, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Both held valid for four operations with rsp_ready high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_a = 16'd1; req0_b = 16'd2; req0_sel = 3'b000; req0_valid = 1'b1;
    req1_a = 16'd7; req1_b = 16'd9; req1_sel = 3'b011; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    ng = 0; nr = 0; gseq = '0; both_hi = 1'b0;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (req0_ready && req1_ready) both_hi = 1'b1;
      if ((req0_ready || req1_ready) && ng < 4) begin
        gseq[ng] = req1_ready;
        ng++;
      end
      if (rsp_valid === 1'b1 && nr < 4) begin
        chk("rr_rsp_data", rsp_data, rsp_id ? 16'd7 : 16'd3);
        nr++;
        if (nr == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
          break;
        end
      end
      tick();
    end
    chk("rr_grant_count", ng, 4);
    chk("rr_resp_count", nr, 4);
    chk("rr_single_ready", both_hi, 0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    chk("rr_grant_order", gseq, 4'b1010);
`else
    chk("rr_grant_order", gseq, 4'b0000);
`endif
    tick();
    rsp_ready = 1'b0;
    tick();

    // Backpressure: five stalled RESP cycles while req0 waits.
    req1_a = 16'd0; req1_b = 16'h1234; req1_sel = 3'b100; req1_valid = 1'b1;
    #1;
    chk("bp_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_a = 16'd5; req0_b = 16'd3; req0_sel = 3'b001; req0_valid = 1'b1;
    bad = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin
      if (req0_ready || req1_ready) bad = 1'b1;
      tick();
      n++;
    end
    chk("bp_lat", n, 3);
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h1234 ||
          rsp_z !== 1'b0 || rsp_err !== 1'b0 || req0_ready || req1_ready) bad = 1'b1;
      tick();
    end
    chk("bp_stable", bad, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_handshake_ready", {req0_ready, req1_ready}, 0);
    tick();
    rsp_ready = 1'b0;
    chk("bp_valid_clear", rsp_valid, 0);
    chk("bp_accept_resumes", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 12) begin tick(); n++; end
    chk("bp_next_rsp", {15'd0, rsp_id, rsp_data, rsp_z}, {15'd0, 1'b0, 16'hFFFE, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Illegal opcodes: immediate error response, ALU inputs untouched.
    op(1'b1, 16'h0AAA, 16'h0BBB, 3'b111, 1, 16'd0, 1'b0, 1'b1, "illegal_111");
    chk("illegal_alu_sel", alu_sel, 3'b001);
    chk("illegal_alu_a", alu_a, 16'd5);
    op(1'b0, 16'h0001, 16'h0002, 3'b101, 1, 16'd0, 1'b0, 1'b1, "illegal_101");

    // Reset during CAPTURE discards the operation.
    req0_a = 16'd10; req0_b = 16'd20; req0_sel = 3'b000; req0_valid = 1'b1;
    #1;
    chk("rst_cap_accept", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_cap_valid", rsp_valid, 0);
    chk("rst_cap_alu_sel", alu_sel, 0);
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("rst_cap_no_rsp", bad, 0);
    op(1'b1, 16'd300, 16'd300, 3'b010, 3, 16'd24464, 1'b0, 1'b0, "post_rst_mul");
    op(1'b0, 16'hFFFF, 16'h0001, 3'b000, 3, 16'd0, 1'b1, 1'b0, "add_wrap_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
